// File: rtl/proc_unit.sv
// proc_unit: operand-processing stage fed by mem_ctrl, launched by core_control.
// Applies a 3-bit opcode to each streamed operand pair and returns procc_done
// once the programmed number of pairs has been consumed.
// Build option: define PROC_MUL_EN to include the shift-add multiplier (opcode 101).
// Without it, opcode 101 yields 0 with latency 1 and raises proc_err.
// Reset rst_n is asynchronous and active-high.

module proc_unit #(
  parameter int unsigned DW      = 32,
  parameter int unsigned LW      = 6,
  parameter int unsigned MUL_CYC = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          procc_start,
  input  logic [2:0]    proc_instruction,
  input  logic [LW-1:0] proc_length,
  input  logic [DW-1:0] proc_opa,
  input  logic [DW-1:0] proc_opb,
  input  logic          proc_opnd_valid,
  output logic          proc_opnd_ready,
  output logic [DW-1:0] proc_result,
  output logic          proc_res_valid,
  output logic          procc_done,
  output logic          proc_busy,
  output logic          proc_ovf,
  output logic          proc_err
);

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpAnd = 3'd2;
  localparam logic [2:0] OpOr  = 3'd3;
  localparam logic [2:0] OpXor = 3'd4;
  localparam logic [2:0] OpMul = 3'd5;
  localparam logic [2:0] OpMax = 3'd6;
  localparam logic [2:0] OpSum = 3'd7;

  // The multiplier runs one iteration per operand bit.
  if (MUL_CYC != DW) begin : g_bad_mul_cyc
    $error("MUL_CYC must equal DW");
  end

  typedef enum logic [1:0] {StIdle, StRun, StMul, StDone} state_e;

  state_e        state_q, state_d;
  logic [2:0]    op_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] cnt_q;
  logic [DW-1:0] acc_q;
  logic [DW-1:0] result_q;
  logic          res_valid_q;
  logic          done_q;
  logic          ovf_q;
  logic          err_q;

  logic          accept;
  logic          last_elem;
  logic [DW-1:0] alu_res;
  logic          alu_ovf;
  logic [DW-1:0] ab_sum;
  logic [DW-1:0] acc_sum;
  logic          acc_ovf;

  assign accept    = (state_q == StRun) && proc_opnd_valid;
  // True when the pair being accepted is the final one of the run.
  assign last_elem = (cnt_q + LW'(1)) == len_q;

`ifdef PROC_MUL_EN
  localparam int unsigned CW = $clog2(MUL_CYC + 1);

  logic [DW-1:0] mul_a_q, mul_b_q, mul_p_q, mul_p_next;
  logic [CW-1:0] mul_cnt_q;
  logic          mul_last;

  assign mul_p_next = mul_p_q + (mul_b_q[0] ? mul_a_q : '0);
  assign mul_last   = (state_q == StMul) && (mul_cnt_q == CW'(MUL_CYC - 1));

  // Shift-add multiplier: load on acceptance, one partial product per clock.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      mul_p_q   <= '0;
      mul_cnt_q <= '0;
    end else if (accept && (op_q == OpMul)) begin
      mul_a_q   <= proc_opa;
      mul_b_q   <= proc_opb;
      mul_p_q   <= '0;
      mul_cnt_q <= '0;
    end else if (state_q == StMul) begin
      mul_a_q   <= mul_a_q << 1;
      mul_b_q   <= mul_b_q >> 1;
      mul_p_q   <= mul_p_next;
      mul_cnt_q <= mul_cnt_q + CW'(1);
    end
  end
`endif

  // Single-cycle ALU plus the accumulator step used by SUM.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    ab_sum  = proc_opa + proc_opb;
    acc_sum = acc_q + ab_sum;
    acc_ovf = (acc_q[DW-1] == ab_sum[DW-1]) && (acc_sum[DW-1] != acc_q[DW-1]);
    case (op_q)
      OpAdd: begin
        alu_res = ab_sum;
        alu_ovf = (proc_opa[DW-1] == proc_opb[DW-1]) && (ab_sum[DW-1] != proc_opa[DW-1]);
      end
      OpSub: begin
        alu_res = proc_opa - proc_opb;
        alu_ovf = (proc_opa[DW-1] != proc_opb[DW-1]) && (alu_res[DW-1] != proc_opa[DW-1]);
      end
      OpAnd:   alu_res = proc_opa & proc_opb;
      OpOr:    alu_res = proc_opa | proc_opb;
      OpXor:   alu_res = proc_opa ^ proc_opb;
      OpMax:   alu_res = ($signed(proc_opa) > $signed(proc_opb)) ? proc_opa : proc_opb;
      default: alu_res = '0;  // MUL and SUM produce their results elsewhere
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (procc_start) begin
          state_d = (proc_length == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (accept) begin
          if (last_elem) begin
            state_d = StDone;
          end
`ifdef PROC_MUL_EN
          // A multiply always detours through StMul, even for the last pair.
          if (op_q == OpMul) begin
            state_d = StMul;
          end
`endif
        end
      end
      StMul: begin
`ifdef PROC_MUL_EN
        if (mul_last) begin
          state_d = (cnt_q == len_q) ? StDone : StRun;
        end
`else
        state_d = StIdle;
`endif
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM-decoded outputs.
  always_comb begin
    proc_busy       = (state_q != StIdle);
    proc_opnd_ready = (state_q == StRun);
  end

  // Datapath: launch capture, per-element results, sticky flags, completion pulse.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      op_q        <= OpAdd;
      len_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      // Completion is reported in the cycle after the FSM leaves StDone.
      done_q      <= (state_q == StDone);

      if ((state_q == StIdle) && procc_start) begin
        op_q  <= proc_instruction;
        len_q <= proc_length;
        cnt_q <= '0;
        acc_q <= '0;
        ovf_q <= 1'b0;
        err_q <= 1'b0;
      end

      if (accept) begin
        cnt_q <= cnt_q + LW'(1);
        case (op_q)
          OpSum: begin
            acc_q <= acc_sum;
            if (acc_ovf) begin
              ovf_q <= 1'b1;
            end
          end
          OpMul: begin
`ifndef PROC_MUL_EN
            result_q    <= '0;
            res_valid_q <= 1'b1;
            err_q       <= 1'b1;
`endif
          end
          default: begin
            result_q    <= alu_res;
            res_valid_q <= 1'b1;
            if (alu_ovf) begin
              ovf_q <= 1'b1;
            end
          end
        endcase
      end

`ifdef PROC_MUL_EN
      if (mul_last) begin
        result_q    <= mul_p_next;
        res_valid_q <= 1'b1;
      end
`endif

      if ((state_q == StDone) && (op_q == OpSum) && (len_q != '0)) begin
        result_q    <= acc_q;
        res_valid_q <= 1'b1;
      end
    end
  end

  assign proc_result    = result_q;
  assign proc_res_valid = res_valid_q;
  assign procc_done     = done_q;
  assign proc_ovf       = ovf_q;
  assign proc_err       = err_q;

endmodule

// File: doc/proc_unit.md
# proc_unit

Operand-processing stage directly downstream of `mem_ctrl`/`core_control`. It is launched by `procc_start`, consumes the opa/opb operand pairs streamed out of the memory controller, applies the 3-bit instruction to each pair, and emits results. When the programmed length has been consumed, it returns `procc_done` to `core_control`.

## Interface
Parameters:
- `DW`, 32: operand and result width.
- `LW`, 6: length field width; must match `mc_data_length`.
- `MUL_CYC`, 32: iterations of the shift-add multiplier; must equal `DW`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-high.
- `procc_start`  in  1  one-cycle launch pulse from `core_control`.
- `proc_instruction`  in  3  opcode; sampled on `procc_start`.
- `proc_length`  in  LW  number of operand pairs; sampled on `procc_start`.
- `proc_opa`, `proc_opb`  in  DW  operand pair from `mem_ctrl`.
- `proc_opnd_valid`  in  1  operand pair is present.
- `proc_opnd_ready`  out  1  unit accepts an operand pair this cycle.
- `proc_result`  out  DW  result word.
- `proc_res_valid`  out  1  `proc_result` valid for one cycle; no backpressure.
- `procc_done`  out  1  one-cycle completion pulse to `core_control`.
- `proc_busy`  out  1  high in every state except IDLE.
- `proc_ovf`  out  1  sticky signed overflow.
- `proc_err`  out  1  sticky illegal-operation flag.

## Operation
- Opcodes: 000 ADD, 001 SUB (a−b), 010 AND, 011 OR, 100 XOR, 101 MUL (low DW bits of the unsigned product), 110 MAX (signed), 111 SUM (running accumulation of a+b).
- Arithmetic wraps modulo 2^DW.
- `proc_ovf` is set on signed overflow of ADD, SUB, or any SUM accumulation step.
- FSM states: IDLE, RUN, MUL, DONE.
- IDLE → RUN on `procc_start`. The start edge latches opcode and length, clears the element counter, the accumulator, `proc_ovf` and `proc_err`.
- `procc_start` with length 0 goes IDLE → DONE directly; no results are produced.
- RUN:
  - `proc_opnd_ready` = 1.
  - An operand pair is accepted when `proc_opnd_valid` && `proc_opnd_ready`; each acceptance increments the element counter.
  - Non-MUL, non-SUM opcodes register the result at the acceptance edge.
  - MUL moves to state MUL.
  - SUM updates the accumulator only; no per-element result.
  - Acceptance of pair number `length` moves to DONE; for MUL it moves to DONE when the final multiply completes.
- MUL:
  - `proc_opnd_ready` = 0.
  - One shift-add iteration per clock for `MUL_CYC` clocks, then the result is registered.
  - Returns to RUN, or goes to DONE after the last element.
- DONE:
  - `procc_done` = 1 for exactly one cycle, then IDLE.
  - For SUM, `proc_result` = accumulator and `proc_res_valid` = 1 in the same cycle.
- `procc_start` while `proc_busy` is ignored.
- `proc_opnd_valid` outside RUN is ignored.
- Reset mid-operation aborts immediately; no `procc_done` is issued.
- Reset values: `proc_opnd_ready`, `proc_res_valid`, `procc_done`, `proc_busy`, `proc_ovf` and `proc_err` are all 0; `proc_result` = 0; state IDLE.
- `proc_result` holds its last value while `proc_res_valid` = 0.

## Timing
- Start edge S: `proc_busy` and `proc_opnd_ready` are high in the cycle after S.
- Non-MUL latency 1: pair accepted at edge E → `proc_res_valid` high in the cycle after E.
- MUL latency `MUL_CYC`+1: pair accepted at E → `proc_res_valid` high in the cycle after E+MUL_CYC. `proc_opnd_ready` is low from E+1 through E+MUL_CYC and high again after E+MUL_CYC if elements remain.
- Back-to-back non-MUL pairs are accepted every cycle.
- Completion: last non-MUL pair at edge E → last `proc_res_valid` in the cycle after E, `procc_done` in the cycle after E+1. For SUM, result and `procc_done` coincide in the cycle after E+1.
- Length 0: `procc_done` in the cycle after S+1.

## Configuration
- `PROC_MUL_EN` defined:
  - MUL is implemented as described.
  - MUL state and multiplier registers are present.
- `PROC_MUL_EN` undefined:
  - No multiplier hardware; state MUL is unreachable.
  - Opcode 101 is accepted with latency 1 and yields `proc_result` = 0.
  - `proc_err` is set and stays set until the next `procc_start`.
  - All other opcodes are unaffected.

## Test plan
- Reset asserted mid-run → all outputs 0 on the next sample, FSM in IDLE, no `procc_done`. After release, a new start works normally.
- ADD, length 3, pairs (1,2), (0x7FFFFFFF,1), (5,5), valid every cycle:
  - results 3, 0x80000000, 10 on consecutive cycles;
  - `proc_ovf` = 1;
  - `procc_done` one cycle after the last result.
- SUM, length 14, opa 11111111..1717171, opb 66611111..6617171 (decimal, as loaded by the system bench):
  - single `proc_res_valid` carrying the modulo-2^32 total, coincident with `procc_done`;
  - no earlier `proc_res_valid`.
- MUL with `PROC_MUL_EN`, length 2, pairs (3,7), (0x10000,0x10000):
  - results 21 and 0, each 33 cycles after acceptance;
  - ready low during each multiply.
  - Without the macro, the same run gives results 0, 0 with latency 1 and `proc_err` = 1.
- Length 0 start → `procc_done` two cycles after start, no `proc_res_valid`. A second `procc_start` issued while busy during a length-4 MAX run is ignored.
